// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: sizing constants, entry layout and tag wrap helper.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH = 31;
    localparam int unsigned ROB_TAG_W = 5;
    localparam int unsigned NO_TAG    = 0;

    typedef struct packed {
        logic        busy;
        logic        complete;
        logic [4:0]  dest;
        logic [31:0] value;
    } rob_entry_t;

    // Tags live in 1..depth; 0 is reserved for "no tag".
    function automatic int unsigned rob_tag_inc(input int unsigned tag, input int unsigned depth);
        return (tag >= depth) ? 1 : tag + 1;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / operand-read / retire bundle between the pipeline (master) and the ROB (slave).
interface reorder_buffer_if #(
    parameter int unsigned TAG_W = 5
);
    logic             dispatch_valid;
    logic [4:0]       dispatch_dest;
    logic             dispatch_ready;
    logic [TAG_W-1:0] dispatch_tag;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;

    logic [TAG_W-1:0] rs1_read_tag;
    logic [TAG_W-1:0] rs2_read_tag;
    logic [31:0]      rs1_value;
    logic [31:0]      rs2_value;
    logic             rs1_value_valid;
    logic             rs2_value_valid;

    logic             retire_valid;
    logic [4:0]       retire_addr;
    logic [TAG_W-1:0] retire_tag;
    logic [31:0]      retire_value;

    logic             flush;
    logic [5:0]       count;

    modport master (
        output dispatch_valid, dispatch_dest, cdb_valid, cdb_tag, cdb_value,
               rs1_read_tag, rs2_read_tag, flush,
        input  dispatch_ready, dispatch_tag, rs1_value, rs2_value,
               rs1_value_valid, rs2_value_valid,
               retire_valid, retire_addr, retire_tag, retire_value, count
    );

    modport slave (
        input  dispatch_valid, dispatch_dest, cdb_valid, cdb_tag, cdb_value,
               rs1_read_tag, rs2_read_tag, flush,
        output dispatch_ready, dispatch_tag, rs1_value, rs2_value,
               rs1_value_valid, rs2_value_valid,
               retire_valid, retire_addr, retire_tag, retire_value, count
    );

endinterface

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: issues tags at dispatch, captures CDB results, retires in program order,
// and serves completed-but-unretired values (with CDB forwarding) to the operand read ports.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH,
    parameter int unsigned TAG_W = ROB_TAG_W
) (
    input  logic            clock,
    input  logic            reset,
    reorder_buffer_if.slave rob
);

    localparam int unsigned SLOTS = 2 ** TAG_W;

    // Indexed directly by tag; slot 0 and any slot above DEPTH are never allocated.
    rob_entry_t entries [SLOTS];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [5:0]       count_q;
    logic             ready_q;

    rob_entry_t       head_entry;
    logic             head_empty;
    logic             dispatch_accept;
    logic             complete_hit;
    logic             retire_fire;
    logic [5:0]       count_next;

    function automatic logic [32:0] lookup(
        input logic [TAG_W-1:0] tag,
        input logic             busy,
        input logic             complete,
        input logic [31:0]      value,
        input logic             cv,
        input logic [TAG_W-1:0] ct,
        input logic [31:0]      cval
    );
        if (tag == TAG_W'(NO_TAG)) return '0;
        if (cv && (ct == tag) && busy) return {1'b1, cval};
        return {busy && complete, value};
    endfunction

    always_comb begin
        head_entry      = entries[head];
        head_empty      = (count_q == '0);
        dispatch_accept = rob.dispatch_valid && ready_q;
        complete_hit    = rob.cdb_valid && (rob.cdb_tag != TAG_W'(NO_TAG))
                          && entries[rob.cdb_tag].busy;
        retire_fire     = head_entry.busy && head_entry.complete && !rob.flush;
        count_next      = count_q + 6'(dispatch_accept) - 6'(retire_fire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < SLOTS; i++) entries[i] <= '0;
            head    <= TAG_W'(1);
            tail    <= TAG_W'(1);
            count_q <= '0;
            ready_q <= 1'b1;
        end else if (rob.flush) begin
            // Values are kept; only occupancy is discarded.
            for (int unsigned i = 0; i < SLOTS; i++) entries[i].busy <= 1'b0;
            head    <= TAG_W'(1);
            tail    <= TAG_W'(1);
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            if (dispatch_accept) begin
                entries[tail].busy     <= 1'b1;
                entries[tail].complete <= 1'b0;
                entries[tail].dest     <= rob.dispatch_dest;
                tail                   <= TAG_W'(rob_tag_inc(32'(tail), DEPTH));
            end
            if (complete_hit) begin
                entries[rob.cdb_tag].complete <= 1'b1;
                entries[rob.cdb_tag].value    <= rob.cdb_value;
            end
            if (retire_fire) begin
                entries[head].busy <= 1'b0;
                head               <= TAG_W'(rob_tag_inc(32'(head), DEPTH));
            end
            count_q <= count_next;
            // Registered so a same-cycle retire cannot open a slot for a same-cycle dispatch.
            ready_q <= (count_next < 6'(DEPTH));
        end
    end

    assign rob.dispatch_ready = ready_q;
    assign rob.dispatch_tag   = tail;
    assign rob.count          = count_q;

    assign rob.retire_valid = retire_fire;
    assign rob.retire_addr  = head_empty ? '0 : head_entry.dest;
    assign rob.retire_tag   = head_empty ? '0 : head;
    assign rob.retire_value = head_empty ? '0 : head_entry.value;

    assign {rob.rs1_value_valid, rob.rs1_value} =
        lookup(rob.rs1_read_tag, entries[rob.rs1_read_tag].busy,
               entries[rob.rs1_read_tag].complete, entries[rob.rs1_read_tag].value,
               rob.cdb_valid, rob.cdb_tag, rob.cdb_value);

    assign {rob.rs2_value_valid, rob.rs2_value} =
        lookup(rob.rs2_read_tag, entries[rob.rs2_read_tag].busy,
               entries[rob.rs2_read_tag].complete, entries[rob.rs2_read_tag].value,
               rob.cdb_valid, rob.cdb_tag, rob.cdb_value);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

    logic clock;
    logic reset;
    int   tests;
    int   failures;

    reorder_buffer_if #(.TAG_W(5)) bus ();

    reorder_buffer #(.DEPTH(31), .TAG_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .rob   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        reset    = 1'b1;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_dest  = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_value      = '0;
        bus.rs1_read_tag   = '0;
        bus.rs2_read_tag   = '0;
        bus.flush          = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        bus.rs1_read_tag = 5'd5;
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_ready", 32'(bus.dispatch_ready), 1);
        chk("rst_tag", 32'(bus.dispatch_tag), 1);
        chk("rst_retire_valid", 32'(bus.retire_valid), 0);
        chk("rst_retire_addr", 32'(bus.retire_addr), 0);
        chk("rst_retire_tag", 32'(bus.retire_tag), 0);
        chk("rst_retire_value", bus.retire_value, 0);
        chk("rst_rs1_value", bus.rs1_value, 0);
        chk("rst_rs1_valid", 32'(bus.rs1_value_valid), 0);

        // Three dispatches: dest 3,4,5 -> tags 1,2,3
        bus.dispatch_valid = 1'b1;
        bus.dispatch_dest  = 5'd3;
        chk("disp1_tag", 32'(bus.dispatch_tag), 1);
        tick();
        bus.dispatch_dest = 5'd4;
        chk("disp2_tag", 32'(bus.dispatch_tag), 2);
        tick();
        bus.dispatch_dest = 5'd5;
        chk("disp3_tag", 32'(bus.dispatch_tag), 3);
        tick();
        bus.dispatch_valid = 1'b0;
        chk("disp_count", 32'(bus.count), 3);
        chk("disp_retire_valid", 32'(bus.retire_valid), 0);
        chk("disp_head_addr", 32'(bus.retire_addr), 3);

        // Out-of-order completion: tag 2 then tag 1
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 5'd2;
        bus.cdb_value = 32'hAA;
        tick();
        chk("ooo_no_retire_t2", 32'(bus.retire_valid), 0);
        bus.cdb_tag   = 5'd1;
        bus.cdb_value = 32'h55;
        #1;
        chk("ooo_no_bypass", 32'(bus.retire_valid), 0);
        tick();
        bus.cdb_valid = 1'b0;
        #1;
        chk("ret1_valid", 32'(bus.retire_valid), 1);
        chk("ret1_addr", 32'(bus.retire_addr), 3);
        chk("ret1_tag", 32'(bus.retire_tag), 1);
        chk("ret1_value", bus.retire_value, 32'h55);
        tick();
        chk("ret2_valid", 32'(bus.retire_valid), 1);
        chk("ret2_addr", 32'(bus.retire_addr), 4);
        chk("ret2_tag", 32'(bus.retire_tag), 2);
        chk("ret2_value", bus.retire_value, 32'hAA);
        chk("ret2_count", 32'(bus.count), 2);
        tick();
        chk("ret_done_valid", 32'(bus.retire_valid), 0);
        chk("ret_done_count", 32'(bus.count), 1);
        chk("ret_done_head", 32'(bus.retire_tag), 3);

        // CDB forwarding on operand read
        bus.dispatch_valid = 1'b1;
        bus.dispatch_dest  = 5'd7;
        chk("fwd_disp_tag", 32'(bus.dispatch_tag), 4);
        tick();
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid    = 1'b1;
        bus.cdb_tag      = 5'd4;
        bus.cdb_value    = 32'h1234;
        bus.rs1_read_tag = 5'd4;
        bus.rs2_read_tag = 5'd3;
        #1;
        chk("fwd_rs1_value", bus.rs1_value, 32'h1234);
        chk("fwd_rs1_valid", 32'(bus.rs1_value_valid), 1);
        chk("fwd_rs2_valid", 32'(bus.rs2_value_valid), 0);
        tick();
        bus.cdb_valid = 1'b0;
        #1;
        chk("stored_rs1_value", bus.rs1_value, 32'h1234);
        chk("stored_rs1_valid", 32'(bus.rs1_value_valid), 1);

        // Ignored CDB traffic: non-busy tag 7, then tag 0
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 5'd7;
        bus.cdb_value = 32'hDEAD;
        tick();
        bus.cdb_tag   = 5'd0;
        bus.cdb_value = 32'hBEEF;
        tick();
        bus.cdb_valid    = 1'b0;
        bus.rs1_read_tag = 5'd7;
        bus.rs2_read_tag = 5'd0;
        #1;
        chk("ign_count", 32'(bus.count), 2);
        chk("ign_rs1_valid", 32'(bus.rs1_value_valid), 0);
        chk("ign_rs1_value", bus.rs1_value, 0);
        chk("ign_rs2_tag0_value", bus.rs2_value, 0);
        chk("ign_rs2_tag0_valid", 32'(bus.rs2_value_valid), 0);
        chk("ign_dispatch_tag", 32'(bus.dispatch_tag), 5);

        // Flush with traffic in flight
        bus.dispatch_valid = 1'b1;
        bus.dispatch_dest  = 5'd8;
        tick();
        tick();
        tick();
        bus.dispatch_valid = 1'b0;
        chk("pre_flush_count", 32'(bus.count), 5);
        bus.flush          = 1'b1;
        bus.dispatch_valid = 1'b1;
        bus.dispatch_dest  = 5'd9;
        bus.cdb_valid      = 1'b1;
        bus.cdb_tag        = 5'd3;
        bus.cdb_value      = 32'h77;
        tick();
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid      = 1'b0;
        bus.rs1_read_tag   = 5'd3;
        #1;
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_tag", 32'(bus.dispatch_tag), 1);
        chk("flush_ready", 32'(bus.dispatch_ready), 1);
        chk("flush_retire_valid", 32'(bus.retire_valid), 0);
        chk("flush_retire_tag", 32'(bus.retire_tag), 0);
        chk("flush_rs1_valid", 32'(bus.rs1_value_valid), 0);

        // Fill and wrap
        bus.dispatch_valid = 1'b1;
        for (int i = 0; i < 31; i++) begin
            bus.dispatch_dest = 5'(i + 1);
            tick();
        end
        chk("full_count", 32'(bus.count), 31);
        chk("full_ready", 32'(bus.dispatch_ready), 0);
        chk("full_tag", 32'(bus.dispatch_tag), 1);
        bus.dispatch_dest = 5'd30;
        tick();
        bus.dispatch_valid = 1'b0;
        chk("over_count", 32'(bus.count), 31);
        chk("over_tag", 32'(bus.dispatch_tag), 1);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 5'd1;
        bus.cdb_value = 32'h99;
        tick();
        bus.cdb_valid = 1'b0;
        #1;
        chk("wrap_ret_valid", 32'(bus.retire_valid), 1);
        chk("wrap_ret_addr", 32'(bus.retire_addr), 1);
        chk("wrap_ret_value", bus.retire_value, 32'h99);
        chk("wrap_ready_still0", 32'(bus.dispatch_ready), 0);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_dest  = 5'd17;
        tick();
        chk("wrap_no_same_cycle_count", 32'(bus.count), 30);
        chk("wrap_ready", 32'(bus.dispatch_ready), 1);
        chk("wrap_tag", 32'(bus.dispatch_tag), 1);
        chk("wrap_head", 32'(bus.retire_tag), 2);
        tick();
        bus.dispatch_valid = 1'b0;
        chk("wrap_refill_count", 32'(bus.count), 31);
        chk("wrap_refill_tag", 32'(bus.dispatch_tag), 2);
        chk("wrap_refill_ready", 32'(bus.dispatch_ready), 0);

        // Mid-operation reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_count", 32'(bus.count), 0);
        chk("rst2_tag", 32'(bus.dispatch_tag), 1);
        chk("rst2_retire_tag", 32'(bus.retire_tag), 0);
        chk("rst2_rs1_value", bus.rs1_value, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer that issues rename tags at dispatch, captures results from the CDB, and retires completed instructions in program order. It sits beside the register map table. Its tail tag feeds the map table's tag input, and its retire outputs drive the map table's retire port and the architectural register file. It also gives the reservation-station path read access to values that are complete but not yet retired.

## Interface
- `DEPTH`, default 31: number of usable entries. Tags run 1..DEPTH; tag 0 is reserved to mean "no tag".
- `TAG_W`, default 5: tag width. Requires DEPTH ≤ 2^TAG_W − 1.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `dispatch_valid`  in  1  allocate an entry this cycle
- `dispatch_dest`  in  5  architectural destination register of the dispatching instruction
- `dispatch_ready`  out  1  an entry is free (count < DEPTH)
- `dispatch_tag`  out  TAG_W  tag the next allocation receives (the tail)
- `cdb_valid`  in  1  CDB broadcast present
- `cdb_tag`  in  TAG_W  tag of the completing instruction
- `cdb_value`  in  32  result of the completing instruction
- `rs1_read_tag`, `rs2_read_tag`  in  TAG_W  operand tags to look up
- `rs1_value`, `rs2_value`  out  32  value held in the looked-up entry
- `rs1_value_valid`, `rs2_value_valid`  out  1  looked-up entry is busy and complete
- `retire_valid`  out  1  head entry retires this cycle
- `retire_addr`  out  5  destination register of the head entry
- `retire_tag`  out  TAG_W  tag of the head entry
- `retire_value`  out  32  result of the head entry
- `flush`  in  1  squash all entries
- `count`  out  6  number of occupied entries

## Operation
- Storage: DEPTH entries, each holding busy, complete, dest[4:0] and value[31:0], indexed by tag. Head and tail pointers are held as tags in the range 1..DEPTH. Incrementing past DEPTH wraps to 1.
- **Dispatch:** on a cycle with `dispatch_valid && dispatch_ready`:
  - entry[tail] is set to busy=1, complete=0, dest=`dispatch_dest`;
  - tail increments.
  - A dispatch while `dispatch_ready`=0 is ignored, with no state change.
- **Complete:** on a cycle with `cdb_valid`, a nonzero `cdb_tag`, and entry[`cdb_tag`].busy:
  - complete is set to 1 and value is written.
  - A CDB tag of 0, or one naming a non-busy entry, is ignored.
- **Retire:**
  - `retire_valid` = entry[head].busy && entry[head].complete && !flush.
  - `retire_addr`, `retire_tag` and `retire_value` show the head entry. When the buffer is empty they show 0.
  - Retirement is unconditional, with no backpressure. On the retire edge, entry[head].busy is cleared and head increments.
  - An entry with dest = x0 still retires normally; consumers ignore the write.
- **Operand read:** combinational. If `cdb_valid` and `cdb_tag` equals the read tag (nonzero) and that entry is busy, the read forwards `cdb_value` with valid=1. Otherwise it returns the stored entry. A read tag of 0 returns value 0 with valid=0.
- **Count:** next count = count + dispatch_accepted − retire_valid. Simultaneous dispatch and retire leave count unchanged.
- **Flush:** takes priority over dispatch, complete and retire. On the flush edge, all busy bits clear, head = tail = 1, and count = 0.

## Timing
- Reset values (after the reset edge):
  - all entries not busy; head = tail = 1; count = 0;
  - `dispatch_ready`=1, `dispatch_tag`=1;
  - `retire_valid`=0, `retire_addr`=0, `retire_tag`=0, `retire_value`=0;
  - `rs*_value`=0 and `rs*_value_valid`=0 for any tag.
- `dispatch_tag` and `dispatch_ready` come from registers, with no combinational path from `dispatch_valid`.
- Completion becomes visible to retire the cycle after the CDB broadcast. There is no same-cycle CDB→retire bypass. Minimum dispatch-to-retire latency is 2 cycles.
- Full condition: `dispatch_ready` is based only on registered count. A retire in the same cycle does not free a slot for a dispatch in that cycle.
- A CDB broadcast to the head entry in the same cycle that a different, older state retires is not possible, because retirement is strictly in order.
- `reset` asserted mid-operation discards all in-flight entries exactly as flush does, and outputs return to the reset values.

## Structure
- Shared package (alongside the existing sys_defs):
  - constants `ROB_DEPTH` = 31, `ROB_TAG_W` = 5, `NO_TAG` = 0;
  - struct `rob_entry_t` {busy, complete, dest[4:0], value[31:0]};
  - function `rob_tag_inc` implementing the 1..DEPTH wrap.
- No sub-module. The entry array, the pointers and the read/forward muxes all live in `reorder_buffer`.

## Test plan
- **Reset, then three dispatches:** reset, then dispatch dest 3, 4, 5 → tags 1, 2, 3 issued; `count`=3; `retire_valid`=0.
- **Out-of-order completion:** CDB tag 2 value 0xAA, then tag 1 value 0x55. Expected:
  - tag 1 retires the cycle after its broadcast, with addr 3 and value 0x55;
  - tag 2 retires the next cycle, with addr 4 and value 0xAA.
- **Fill and wrap:**
  - dispatch 31 entries → `dispatch_ready`=0, `dispatch_tag`=1;
  - a 32nd `dispatch_valid` is ignored;
  - complete and retire tag 1, then dispatch → the new entry receives tag 1.
- **CDB forwarding on the operand read:** dispatch to tag 4, then broadcast CDB tag 4 value 0x1234 with `rs1_read_tag`=4 in that cycle → `rs1_value`=0x1234 and `rs1_value_valid`=1 in the same cycle.
- **Ignored CDB traffic:** a CDB broadcast to a non-busy tag 7, and a broadcast to tag 0 → no state change; `count` unchanged.
- **Flush with traffic in flight:** 5 entries in flight, with `flush` asserted together with `dispatch_valid` and a CDB broadcast → next cycle `count`=0, `dispatch_tag`=1, `retire_valid`=0.
